// File: rtl/cpu_types_pkg.sv
// Shared types for the cache block's memory-side arbiter: RAM status, data word, arbiter FSM state.
// Also holds the starvation counter width and its saturating increment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_CNT_W = 4;
  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

  function automatic starve_cnt_t starve_sat_inc(input starve_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + starve_cnt_t'(1);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Memory-side bundle between the two caches, the shared RAM port and the arbiter.
// master = arbiter view; slave = the caches and RAM view.
interface cache_mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache: data wins by default, a starvation counter forces a fetch.
// Grant is held until the RAM reports ACCESS; completion (wait low, load valid) is combinational in that cycle.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  cache_mem_arbiter_if.master        bus
);

  localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  starve_cnt_t starve_cnt_q, starve_cnt_d;
  logic        d_req;
  logic        ram_access;

  assign d_req      = bus.dREN | bus.dWEN;
  assign ram_access = (bus.ramstate == ACCESS);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!bus.iREN || (starve_cnt_q < LIMIT))) begin
          state_d      = DGRANT;
          starve_cnt_d = bus.iREN ? starve_sat_inc(starve_cnt_q) : '0;
        end else if (bus.iREN) begin
          state_d      = IGRANT;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end
      // A dropped request releases the grant without signalling completion.
      IGRANT: if (!bus.iREN || ram_access) state_d = IDLE;
      DGRANT: if (!d_req || ram_access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Address and data are driven live from the granted requester, never latched.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (state_q)
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (bus.iREN && ram_access) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      DGRANT: begin
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (d_req && ram_access) begin
          bus.dwait = 1'b0;
          if (!bus.dWEN) bus.dload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequences the single shared RAM port between the instruction cache and the data cache behind the cache block's memory-side interface. Grants one requester at a time, holds the grant until the RAM reports completion, and routes load data and wait signals back to the owning cache. Data requests win by default; a starvation counter guarantees instruction fetch progress under a continuous data stream.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while `iREN` is pending before a fetch is forced. Legal range 1..15.

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  reset, synchronous to `CLK`, active-high.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request. `dREN` and `dWEN` high together is illegal; `dWEN` wins.
- `daddr`  in  32  dcache address.
- `dstore`  in  32  dcache write data.
- `iwait`  out  1  low for exactly the cycle the icache access completes.
- `dwait`  out  1  low for exactly the cycle the dcache access completes.
- `iload`  out  32  fetched word; valid when `iwait` is low.
- `dload`  out  32  loaded word; valid when `dwait` is low after a read.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, IGRANT, DGRANT. Reset state IDLE.
- IDLE: if no request, stay. If a data request (`dREN|dWEN`) is present and (`iREN` low or `starve_cnt < STARVE_LIMIT`), go to DGRANT. Otherwise, if `iREN` is high, go to IGRANT.
- IGRANT: `ramREN=1`, `ramaddr=iaddr`. When `ramstate==ACCESS`, `iwait=0` and `iload=ramload`, and the next state is IDLE.
- DGRANT: `ramREN=dREN&~dWEN`, `ramWEN=dWEN`, `ramaddr=daddr`, `ramstore=dstore`. When `ramstate==ACCESS`, `dwait=0`, `dload=ramload` on a read, and the next state is IDLE.
- BUSY, FREE and ERROR while granted keep the grant. An access is never abandoned. ERROR is treated as BUSY and the RAM retries.
- Requesters hold their request and operands stable until their wait drops. The arbiter does not latch address or data. It drives them live from the granted requester.
- A requester that drops its request mid-grant is a protocol violation. The arbiter releases the grant to IDLE on the next cycle without asserting that requester's wait low.
- `starve_cnt` is 4 bits. It increments on entry to DGRANT when `iREN` is high, saturating at 15. It clears on entry to IGRANT, and clears in any IDLE cycle with `iREN` low.
- Outputs when not granted or in IDLE: `iwait=1`, `dwait=1`, `ram*` all 0, `iload=0`, `dload=0`.
- Reset: FSM to IDLE, `starve_cnt=0`. All outputs take the idle values on the cycle after `RST` is sampled high, including when reset arrives mid-grant. An in-flight access is dropped and not completed.

## Timing
- A request visible in IDLE at edge n is granted from cycle n+1.
- Completion is combinational in the ACCESS cycle: wait low and load valid in the same cycle.
- The FSM returns to IDLE at the following edge. The minimum back-to-back turnaround is one IDLE cycle between grants.
- Minimum latency from request to wait low is 2 cycles (1 arbitration + 1 RAM cycle if ACCESS is immediate).
- With `STARVE_LIMIT=L` and continuous data traffic, a pending fetch is granted after at most L data accesses.

## Structure
- `ramstate_t`, `word_t` and the FSM state enum `arb_state_t` live in `cpu_types_pkg`.
- A single module. No sub-module is needed. The starvation counter is inline.

## Test plan
- Lone fetch: `iREN=1`, `iaddr=0x0000_0040`, RAM gives ACCESS on its first granted cycle with `ramload=0x2400_0001` -> `ramREN` high in cycle 1, `iwait=0` with `iload=0x2400_0001` in cycle 1, back in IDLE in cycle 2.
- Simultaneous requests: `iREN` and `dWEN` both high, `daddr=0x100`, `dstore=0xDEAD_BEEF` -> the data write is granted first with `ramWEN=1` and `ramstore=0xDEAD_BEEF`. Then `dwait=0`. The fetch is granted after one IDLE cycle.
- Starvation: `STARVE_LIMIT=2`, `dREN` continuously high, `iREN` high -> the grant order is D, D, I, D, D, I. `iwait` drops after the third access.
- RAM stalls: ramstate sequence BUSY, BUSY, ERROR, ACCESS during a DGRANT read -> `dwait` stays 1 for three cycles and drops in the fourth with `dload=ramload`. No request switching occurs.
- Reset mid-grant: `RST` asserted during an IGRANT with ramstate BUSY -> the next cycle has all `ram*`=0, `iwait=dwait=1` and `starve_cnt=0`. After `RST` is released, a new fetch is granted normally.
- Idle outputs: no requests for 10 cycles -> `ramREN=ramWEN=0`, `iwait=dwait=1`, and both loads are 0 throughout.
